// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: op encoding (funct3),
// FSM states and small op-decode helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Result comes from the upper half of the shared register: high product or remainder.
    function automatic logic op_takes_hi(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit_datapath.sv
// Purpose: shared shift register (product / remainder:quotient), adder/subtractor, sign-fix negator.
// Latency: one mul or div step per enabled cycle; fix_dat is combinational from the register.
// Backpressure: none; holds state whenever no control strobe is asserted.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_vld,
    input  logic [2*WIDTH-1:0] load_acc_dat,
    input  logic [WIDTH-1:0]   load_opnd_dat,
    input  logic               mul_step,
    input  logic               div_step,
    input  logic               fix_vld,
    input  logic               fix_neg_lo,
    input  logic               fix_neg_hi,
    input  logic               fix_chain,
    output logic [2*WIDTH-1:0] fix_dat
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     sum, rem_sh, trial, lo_neg;
    logic [WIDTH-1:0]   hi_neg;
    logic               hi_cin;

    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

    always_comb begin
        sum    = {1'b0, acc_hi} + {1'b0, opnd_q};
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, opnd_q};
        lo_neg = {1'b0, ~acc_lo} + (WIDTH+1)'(1);
        // Chained: one 2W negate of the product; unchained: remainder and quotient negate independently.
        hi_cin = fix_chain ? lo_neg[WIDTH] : 1'b1;
        hi_neg = ~acc_hi + {{(WIDTH-1){1'b0}}, hi_cin};
        fix_dat = {(fix_neg_hi ? hi_neg : acc_hi),
                   (fix_neg_lo ? lo_neg[WIDTH-1:0] : acc_lo)};
    end

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load_vld) begin
            acc_d  = load_acc_dat;
            opnd_d = load_opnd_dat;
        end else if (mul_step) begin
            acc_d = {(acc_q[0] ? sum : {1'b0, acc_hi}), acc_lo[WIDTH-1:1]};
        end else if (div_step) begin
            // Borrow clear means the shifted remainder covers the divisor: keep the difference.
            if (!trial[WIDTH]) begin
                acc_d = {trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (fix_vld) begin
            acc_d = fix_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Purpose: RV32M multi-cycle multiply/divide unit, one bit per cycle over magnitudes.
// Latency: out_valid WIDTH+2 cycles after accept; divide-by-zero / signed overflow after 1.
// Backpressure: in_ready only in IDLE; result and out_valid held until out_ready in DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    muldiv_op_t       op_q, op_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             sa_in, sb_in, b_zero, sgn_ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic               load_vld, mul_step, div_step, fix_vld;
    logic               fix_neg_lo, fix_neg_hi, fix_chain;
    logic [2*WIDTH-1:0] load_acc_dat;
    logic [WIDTH-1:0]   load_opnd_dat;
    logic [2*WIDTH-1:0] fix_dat;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

    always_comb begin
        sa_in   = op_signed_a(op) & a_in[WIDTH-1];
        sb_in   = op_signed_b(op) & b_in[WIDTH-1];
        a_mag   = sa_in ? (~a_in + WIDTH'(1)) : a_in;
        b_mag   = sb_in ? (~b_in + WIDTH'(1)) : b_in;
        b_zero  = (b_in == '0);
        sgn_ovf = (op == OP_DIV || op == OP_REM) && (a_in == MIN_VAL) && (b_in == '1);
    end

    always_comb begin
        fix_chain  = !op_is_div(op_q);
        fix_neg_lo = sa_q ^ sb_q;
        fix_neg_hi = fix_chain ? (sa_q ^ sb_q) : sa_q;
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        op_d          = op_q;
        sa_d          = sa_q;
        sb_d          = sb_q;
        result_d      = result_q;
        load_vld      = 1'b0;
        load_acc_dat  = '0;
        load_opnd_dat = '0;
        mul_step      = 1'b0;
        div_step      = 1'b0;
        fix_vld       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    count_d = '0;
                    if (op_is_div(op) && b_zero) begin
                        result_d = op_takes_hi(op) ? a_in : '1;
                        state_d  = S_DONE;
                    end else if (sgn_ovf) begin
                        result_d = op_takes_hi(op) ? '0 : MIN_VAL;
                        state_d  = S_DONE;
                    end else if (op_is_div(op)) begin
                        load_vld      = 1'b1;
                        load_acc_dat  = {{WIDTH{1'b0}}, a_mag};
                        load_opnd_dat = b_mag;
                        state_d       = S_DIV;
                    end else begin
                        load_vld      = 1'b1;
                        load_acc_dat  = {{WIDTH{1'b0}}, b_mag};
                        load_opnd_dat = a_mag;
                        state_d       = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                mul_step = (state_q == S_MUL);
                div_step = (state_q == S_DIV);
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix_vld  = 1'b1;
                result_d = op_takes_hi(op_q) ? fix_dat[2*WIDTH-1:WIDTH] : fix_dat[WIDTH-1:0];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_vld      (load_vld),
        .load_acc_dat  (load_acc_dat),
        .load_opnd_dat (load_opnd_dat),
        .mul_step      (mul_step),
        .div_step      (div_step),
        .fix_vld       (fix_vld),
        .fix_neg_lo    (fix_neg_lo),
        .fix_neg_hi    (fix_neg_hi),
        .fix_chain     (fix_chain),
        .fix_dat       (fix_dat)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results at accept,
// a negedge monitor pops and checks result, latency, hold stability and handshake.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    muldiv_op_t  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          hold;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic of the RV32M definitions.
    function automatic logic [31:0] ref_model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint          ub = b;
        longint unsigned pu = longint'(a) * longint'(b);
        longint          ps;
        logic [63:0]     p;
        int              ai = $signed(a);
        int              bi = $signed(b);
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = pu; return p[31:0]; end
            OP_MULH:   begin ps = sa * sb; p = ps; return p[63:32]; end
            OP_MULHSU: begin ps = sa * ub; p = ps; return p[63:32]; end
            OP_MULHU:  begin p = pu; return p[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ai / bi);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ai % bi);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) &&
                  ((b == 0) || ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return special ? 1 : 34;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            6: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout actual=busy required=in_ready");
            return;
        end
        op       = o;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        e.res    = ref_model(o, a, b);
        e.lat    = ref_lat(o, a, b);
        e.hold   = hold;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
    endtask

    // Monitor: latency, result, stability while held, return to IDLE after release.
    initial begin : monitor
        logic        timing = 1'b0;
        logic        have = 1'b0;
        logic        post_release = 1'b0;
        int          lat = 0;
        int          hold = 0;
        logic [31:0] first = '0;
        exp_t        e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                timing       = 1'b0;
                have         = 1'b0;
                post_release = 1'b0;
                out_ready    = 1'b0;
            end else begin
                if (post_release) begin
                    chk("idle_after_release", {30'b0, in_ready, out_valid}, 32'h2);
                    post_release = 1'b0;
                end
                if (in_valid && in_ready) begin
                    timing = 1'b1;
                    lat    = 0;
                end else if (timing) begin
                    lat++;
                end
                if (out_valid) begin
                    if (!have) begin
                        have  = 1'b1;
                        first = result;
                        if (sb_q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL unexpected_output actual=%h required=none", result);
                            hold = 0;
                        end else begin
                            e = sb_q.pop_front();
                            chk("result", result, e.res);
                            chk("latency", 32'(lat), 32'(e.lat));
                            hold = e.hold;
                        end
                        timing = 1'b0;
                    end else begin
                        chk("result_stable", result, first);
                        chk("in_ready_in_done", {31'b0, in_ready}, 32'h0);
                    end
                    if (hold == 0) begin
                        out_ready    = 1'b1;
                        have         = 1'b0;
                        post_release = 1'b1;
                    end else begin
                        out_ready = 1'b0;
                        hold--;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int guard;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        op       = OP_MUL;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_result", result, 32'h0);
        reset_n = 1'b1;

        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 0);
        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 0);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 2);
        issue(OP_DIVU, 32'd100, 32'd7, 0);
        issue(OP_REMU, 32'd100, 32'd7, 0);
        issue(OP_DIVU, 32'd5, 32'd0, 0);
        issue(OP_REM, 32'd5, 32'd0, 0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(OP_MUL, 32'h1234_5678, 32'h0000_0010, 10);

        // Requests presented while busy must be ignored.
        issue(OP_DIVU, 32'd1000, 32'd3, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            op       = muldiv_op_t'($urandom_range(0, 7));
            a_in     = $urandom;
            b_in     = $urandom;
            #1;
            chk("busy_in_ready", {30'b0, in_ready, busy}, 32'h1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset in the middle of a divide: immediate abort, nothing emitted.
        issue(OP_DIV, 32'd12345678, 32'd77, 0);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'h1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_result", result, 32'h0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(OP_DIV, 32'hFFFF_FF00, 32'd7, 0);

        for (int i = 0; i < 150; i++) begin
            issue(muldiv_op_t'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), int'($urandom_range(0, 3)));
        end

        guard = 0;
        while ((sb_q.size() != 0 || busy) && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
